// File: rtl/reg_serie_para.sv
// reg_serie_para: serial-in / parallel-out SPI receive register.
// Captures synchronized MISO bits on controller strobes and publishes each word.
module reg_serie_para #(
    parameter int WIDTH       = 8,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             sample_i,
    input  logic             abort_i,
    input  logic             miso_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             busy_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [WIDTH-1:0]       r_sreg;
    logic [CW-1:0]          r_cnt;
    logic [WIDTH-1:0]       r_data;
    logic                   r_valid;
    logic                   r_busy;

    logic                   w_miso_s;
    logic [WIDTH-1:0]       w_sreg_nxt;
    logic                   w_last;

    assign w_miso_s = r_sync[SYNC_STAGES-1];
    assign w_last   = (r_cnt == LAST);

    // Bring the asynchronous MISO line into the clock domain.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= miso_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Shift direction decides where the first received bit ends up.
    always_comb begin
        w_sreg_nxt = r_sreg;
        if (MSB_FIRST) begin
            w_sreg_nxt = {r_sreg[WIDTH-2:0], w_miso_s};
        end else begin
            w_sreg_nxt = {w_miso_s, r_sreg[WIDTH-1:1]};
        end
    end

    // Frame FSM; every output is registered alongside the state.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_valid <= 1'b0;
                    if (start_i) begin
                        r_sreg  <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RECV;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                RECV: begin
                    r_valid <= 1'b0;
                    if (abort_i) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (sample_i) begin
                        r_sreg <= w_sreg_nxt;
                        if (w_last) begin
                            r_data  <= w_sreg_nxt;
                            r_valid <= 1'b1;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                            r_state <= DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_valid <= 1'b0;
                    if (start_i) begin
                        r_sreg  <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RECV;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign busy_o  = r_busy;

endmodule

// File: tb/tb_reg_serie_para.sv
// tb_reg_serie_para: scoreboard bench for reg_serie_para.
// One MSB-first and one LSB-first instance share the same stimulus.
module tb_reg_serie_para;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       start_i = 1'b0;
    logic       sample_i = 1'b0;
    logic       abort_i = 1'b0;
    logic       miso_i = 1'b0;
    logic [7:0] m_data, l_data;
    logic       m_valid, l_valid;
    logic       m_busy, l_busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] q_m[$];
    logic [7:0] q_l[$];

    always #50 clk_i = ~clk_i;

    reg_serie_para #(.WIDTH(8), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u_msb (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .sample_i(sample_i), .abort_i(abort_i), .miso_i(miso_i),
        .data_o(m_data), .valid_o(m_valid), .busy_o(m_busy)
    );

    reg_serie_para #(.WIDTH(8), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) u_lsb (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .sample_i(sample_i), .abort_i(abort_i), .miso_i(miso_i),
        .data_o(l_data), .valid_o(l_valid), .busy_o(l_busy)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected words whenever a valid pulse is seen.
    logic m_prev = 1'b0;
    logic l_prev = 1'b0;
    always @(negedge clk_i) begin
        if (m_valid) begin
            chk("msb_valid_not_double", m_prev, 1'b0);
            if (q_m.size() == 0) begin
                chk("msb_unexpected_valid", m_data, 32'hFFFF_FFFF);
            end else begin
                chk("msb_data", m_data, q_m.pop_front());
            end
            chk("msb_busy_in_done", m_busy, 1'b0);
        end
        if (l_valid) begin
            chk("lsb_valid_not_double", l_prev, 1'b0);
            if (q_l.size() == 0) begin
                chk("lsb_unexpected_valid", l_data, 32'hFFFF_FFFF);
            end else begin
                chk("lsb_data", l_data, q_l.pop_front());
            end
            chk("lsb_busy_in_done", l_busy, 1'b0);
        end
        m_prev <= m_valid;
        l_prev <= l_valid;
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_pulse();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        miso_i = b;
        repeat (4) tick();
        sample_i = 1'b1;
        tick();
        sample_i = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(v[7-i]);
        end
    endtask

    task automatic frame(input logic [7:0] v, input logic [7:0] em,
                         input logic [7:0] el);
        q_m.push_back(em);
        q_l.push_back(el);
        start_pulse();
        chk("busy_after_start", {m_busy, l_busy}, 2'b11);
        send_bits(v, 8);
        chk("busy_after_frame", {m_busy, l_busy}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) tick();
        chk("reset_data", {m_data, l_data}, 16'h0000);
        chk("reset_flags", {m_valid, l_valid, m_busy, l_busy}, 4'b0000);
        rst_i = 1'b1;
        tick();

        // A5 and 1,1,0,0,0,0,0,0 in both bit orders
        frame(8'hA5, 8'hA5, 8'hA5);
        frame(8'hC0, 8'hC0, 8'h03);

        // abort mid-frame keeps the previous word
        frame(8'h3C, 8'h3C, 8'h3C);
        start_pulse();
        send_bits(8'hFF, 4);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_busy", {m_busy, l_busy}, 2'b00);
        chk("abort_valid", {m_valid, l_valid}, 2'b00);
        chk("abort_data", {m_data, l_data}, 16'h3C3C);
        frame(8'h81, 8'h81, 8'h81);

        // reset mid-frame discards the partial frame
        start_pulse();
        send_bits(8'hFF, 5);
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        chk("rst_mid_data", {m_data, l_data}, 16'h0000);
        chk("rst_mid_flags", {m_valid, l_valid, m_busy, l_busy}, 4'b0000);
        send_bits(8'hFF, 3);
        chk("rst_tail_busy", {m_busy, l_busy}, 2'b00);
        chk("rst_tail_data", {m_data, l_data}, 16'h0000);

        // back-to-back: start in the DONE cycle
        q_m.push_back(8'hF0);
        q_l.push_back(8'h0F);
        q_m.push_back(8'h0F);
        q_l.push_back(8'hF0);
        start_pulse();
        send_bits(8'hF0, 8);
        start_pulse();
        chk("b2b_busy", {m_busy, l_busy}, 2'b11);
        send_bits(8'h0F, 8);

        // start with a coincident sample: that sample is ignored
        miso_i = 1'b1;
        repeat (4) tick();
        q_m.push_back(8'h96);
        q_l.push_back(8'h69);
        start_i = 1'b1;
        sample_i = 1'b1;
        tick();
        start_i = 1'b0;
        sample_i = 1'b0;
        send_bits(8'h96, 7);
        chk("coinc_still_busy", {m_busy, l_busy}, 2'b11);
        send_bits(8'h00, 1);
        chk("coinc_done_busy", {m_busy, l_busy}, 2'b00);

        // abort with the 8th sample wins
        start_pulse();
        send_bits(8'h55, 7);
        miso_i = 1'b1;
        repeat (4) tick();
        sample_i = 1'b1;
        abort_i = 1'b1;
        tick();
        sample_i = 1'b0;
        abort_i = 1'b0;
        chk("abort8_busy", {m_busy, l_busy}, 2'b00);
        chk("abort8_data", {m_data, l_data}, 16'h9669);

        // samples without start do nothing
        send_bits(8'hFF, 3);
        chk("nostart_busy", {m_busy, l_busy}, 2'b00);
        chk("nostart_data", {m_data, l_data}, 16'h9669);

        repeat (5) tick();
        chk("msb_queue_empty", q_m.size(), 0);
        chk("lsb_queue_empty", q_l.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
